// File: rtl/sync_fifo_swmr_pkg.sv
// Shared defaults and width helpers for the wide-write / narrow-read FIFO.
package sync_fifo_swmr_pkg;

  localparam int DEF_W_WIDTH = 32;
  localparam int DEF_W_DEPTH = 8;
  localparam int DEF_R_WIDTH = 16;

  // rd_level must also represent the completely full count, hence the extra bit.
  function automatic int rd_level_w(input int w_depth, input int ratio);
    return $clog2(w_depth * ratio) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_swmr_if.sv
// Write/read handshake bundle for sync_fifo_swmr; master drives requests, slave is the FIFO.
interface sync_fifo_swmr_if
  import sync_fifo_swmr_pkg::*;
#(
  parameter int W_WIDTH = DEF_W_WIDTH,
  parameter int W_DEPTH = DEF_W_DEPTH,
  parameter int R_WIDTH = DEF_R_WIDTH
) ();

  localparam int LVL_W = rd_level_w(W_DEPTH, W_WIDTH / R_WIDTH);

  logic               wr_en;
  logic [W_WIDTH-1:0] wr_data;
  logic               full;
  logic               wr_err;
  logic               rd_en;
  logic [R_WIDTH-1:0] rd_data;
  logic               rd_valid;
  logic               empty;
  logic               rd_err;
  logic [LVL_W-1:0]   rd_level;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, wr_err, rd_data, rd_valid, empty, rd_err, rd_level
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, wr_err, rd_data, rd_valid, empty, rd_err, rd_level
  );

endinterface

// File: rtl/sync_fifo_swmr.sv
// Synchronous FIFO: wide words written, returned as RATIO narrow lanes LSB first.
// Pointers are kept in their own units so full/empty/level fall out of plain subtraction.
module sync_fifo_swmr
  import sync_fifo_swmr_pkg::*;
#(
  parameter int W_WIDTH = DEF_W_WIDTH,
  parameter int W_DEPTH = DEF_W_DEPTH,
  parameter int R_WIDTH = DEF_R_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  sync_fifo_swmr_if.slave bus
);

  localparam int RATIO        = W_WIDTH / R_WIDTH;
  localparam int R_DEPTH      = W_DEPTH * RATIO;
  localparam int W_ADDR_WIDTH = $clog2(W_DEPTH);
  localparam int R_ADDR_WIDTH = $clog2(R_DEPTH);
  localparam int LANE_W       = $clog2(RATIO);

  logic [W_WIDTH-1:0]          mem [W_DEPTH];
  logic [W_ADDR_WIDTH:0]       wr_ptr;
  logic [R_ADDR_WIDTH:0]       rd_ptr;
  logic [R_ADDR_WIDTH:0]       wr_ptr_narrow;
  logic [W_ADDR_WIDTH:0]       wide_used;
  logic [RATIO-1:0][R_WIDTH-1:0] rd_lanes;
  logic [R_WIDTH-1:0]          rd_data_q;
  logic                        rd_valid_q;
  logic                        wr_err_q;
  logic                        rd_err_q;
  logic                        full;
  logic                        empty;
  logic                        wr_ok;
  logic                        rd_ok;

  assign wr_ptr_narrow = {wr_ptr, {LANE_W{1'b0}}};
  // A partially drained entry still counts as occupied until its last lane goes.
  assign wide_used     = wr_ptr - rd_ptr[R_ADDR_WIDTH:LANE_W];
  assign empty         = (rd_ptr == wr_ptr_narrow);
  assign full          = (wide_used == (W_ADDR_WIDTH + 1)'(W_DEPTH));
  assign wr_ok         = bus.wr_en && !full;
  assign rd_ok         = bus.rd_en && !empty;
  assign rd_lanes      = mem[rd_ptr[R_ADDR_WIDTH-1:LANE_W]];

  // Storage carries no reset so it maps onto a simple dual-port RAM.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      mem[wr_ptr[W_ADDR_WIDTH-1:0]] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      wr_err_q   <= bus.wr_en && full;
      rd_err_q   <= bus.rd_en && empty;
      rd_valid_q <= rd_ok;
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_data_q <= rd_lanes[rd_ptr[LANE_W-1:0]];
        rd_ptr    <= rd_ptr + 1'b1;
      end
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.wr_err   = wr_err_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_level = wr_ptr_narrow - rd_ptr;

endmodule

// File: tb/tb_sync_fifo_swmr.sv
// Bench for sync_fifo_swmr: vector table plus hand sequences, read data checked via a scoreboard.
module tb_sync_fifo_swmr;
  import sync_fifo_swmr_pkg::*;

  localparam int W_WIDTH = 32;
  localparam int W_DEPTH = 8;
  localparam int R_WIDTH = 16;
  localparam int NVEC    = 16;

  typedef struct {
    logic        wr;
    logic [31:0] d;
    logic        rd;
    logic        e_empty;
    logic        e_full;
    logic [4:0]  e_lvl;
    logic        e_werr;
    logic        e_rerr;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_swmr_if #(.W_WIDTH(W_WIDTH), .W_DEPTH(W_DEPTH), .R_WIDTH(R_WIDTH)) bus ();

  sync_fifo_swmr #(.W_WIDTH(W_WIDTH), .W_DEPTH(W_DEPTH), .R_WIDTH(R_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_q[$];
  logic [15:0] sb_q[$];
  logic [15:0] exp_data = '0;
  vec_t        tbl[NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model predicts flags and queues expected read data.
  task automatic step(input logic wr, input logic [31:0] d, input logic rd);
    bit m_full, m_empty, acc_w, acc_r;
    @(negedge clk);
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.rd_en   = rd;
    m_empty = (model_q.size() == 0);
    m_full  = (((model_q.size() + 1) / 2) == W_DEPTH);
    acc_r   = rd && !m_empty;
    acc_w   = wr && !m_full;
    if (acc_r) sb_q.push_back(model_q.pop_front());
    if (acc_w) begin
      model_q.push_back(d[15:0]);
      model_q.push_back(d[31:16]);
    end
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("rd_valid", bus.rd_valid, acc_r);
    if (bus.rd_valid) begin
      if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
      else exp_data = sb_q.pop_front();
    end
    chk("rd_data", bus.rd_data, exp_data);
    chk("wr_err", bus.wr_err, wr && m_full);
    chk("rd_err", bus.rd_err, rd && m_empty);
    chk("empty", bus.empty, model_q.size() == 0);
    chk("full", bus.full, ((model_q.size() + 1) / 2) == W_DEPTH);
    chk("rd_level", bus.rd_level, model_q.size());
  endtask

  // Reset is asserted together with both requests to confirm it has priority.
  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    bus.wr_en   = 1'b1;
    bus.rd_en   = 1'b1;
    bus.wr_data = 32'hFFFF_EEEE;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    model_q.delete();
    sb_q.delete();
    exp_data = '0;
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_level", bus.rd_level, 0);
    chk("rst_valid", bus.rd_valid, 0);
    chk("rst_wr_err", bus.wr_err, 0);
    chk("rst_rd_err", bus.rd_err, 0);
    chk("rst_data", bus.rd_data, 0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;

    tbl[0] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 32'hBBBB_AAAA, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++)
      tbl[4+i] = '{1'b1, {16'hB000 + 16'(i), 16'hA000 + 16'(i)}, 1'b0,
                   1'b0, (i == 7), 5'(2 * (i + 1)), 1'b0, 1'b0};
    tbl[12] = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 5'd16, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 5'd16, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 5'd15, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 5'd14, 1'b0, 1'b0};

    do_reset();

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].wr, tbl[i].d, tbl[i].rd);
      chk($sformatf("tbl%0d_empty", i), bus.empty, tbl[i].e_empty);
      chk($sformatf("tbl%0d_full", i), bus.full, tbl[i].e_full);
      chk($sformatf("tbl%0d_level", i), bus.rd_level, tbl[i].e_lvl);
      chk($sformatf("tbl%0d_wr_err", i), bus.wr_err, tbl[i].e_werr);
      chk($sformatf("tbl%0d_rd_err", i), bus.rd_err, tbl[i].e_rerr);
      if (i == 0) chk("empty_read_data", bus.rd_data, 16'h0000);
      if (i == 2) chk("first_lane", bus.rd_data, 16'hAAAA);
      if (i == 3) chk("second_lane", bus.rd_data, 16'hBBBB);
      if (i == 14) chk("after_full_lane", bus.rd_data, 16'hA000);
    end

    // Drain to a single narrow word, then write and read in the same cycle.
    for (int i = 0; i < 13; i++) step(1'b0, 32'h0, 1'b1);
    chk("lvl_before_simul", bus.rd_level, 1);
    step(1'b1, 32'h2222_1111, 1'b1);
    chk("simul_level", bus.rd_level, 2);
    chk("simul_data", bus.rd_data, 16'hB007);
    step(1'b0, 32'h0, 1'b1);
    chk("simul_lane0", bus.rd_data, 16'h1111);
    step(1'b0, 32'h0, 1'b1);
    chk("simul_lane1", bus.rd_data, 16'h2222);
    chk("simul_empty", bus.empty, 1);

    // Randomised traffic; model and scoreboard carry the expectations.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));

    // Fill until full, then write while a read frees the entry: the write must drop.
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 32'h5000_4000 + 32'(i), 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h9999_8888, 1'b1);
    chk("full_drop_err", bus.wr_err, 1);
    chk("full_drop_level", bus.rd_level, 14);

    // Reset mid-operation discards contents.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h7777_0000 + 32'(i), 1'b0);
    do_reset();
    step(1'b0, 32'h0, 1'b1);
    chk("post_rst_rd_err", bus.rd_err, 1);
    chk("post_rst_valid", bus.rd_valid, 0);

    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
